// File: rtl/escape_room_fsm.sv
// Escape-room puzzle controller: rooms, answer key, lives, room timer.
// Ports: clk/reset, start, answer_valid/answer, key -> state, room,
//   prev_room, lives, correct_pulse, wrong_pulse (all registered).
module escape_room_fsm #(
    parameter int NUM_ROOMS = 6,
    parameter int ANS_W     = 2,
    parameter int MAX_LIVES = 3,
    parameter int TIMEOUT   = 0,
    localparam int RW = $clog2(NUM_ROOMS + 1),
    localparam int LW = $clog2(MAX_LIVES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       answer_valid,
    input  logic [ANS_W-1:0]           answer,
    input  logic [NUM_ROOMS*ANS_W-1:0] key,
    output logic [1:0]                 state,
    output logic [RW-1:0]              room,
    output logic [RW-1:0]              prev_room,
    output logic [LW-1:0]              lives,
    output logic                       correct_pulse,
    output logic                       wrong_pulse
);

    localparam int KW = NUM_ROOMS * ANS_W;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LAST_I);
    localparam logic [RW-1:0] LAST_ROOM = RW'(NUM_ROOMS - 1);
    localparam logic [LW-1:0] FULL_LIVES = LW'(MAX_LIVES);
    localparam logic [LW-1:0] ONE_LIFE = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   room_q, room_d;
    logic [RW-1:0]   prev_room_q, prev_room_d;
    logic [LW-1:0]   lives_q, lives_d;
    logic            correct_q, correct_d;
    logic            wrong_q, wrong_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [KW-1:0]   key_q, key_d;

    logic            in_play;
    logic            start_go;
    logic            ans_hit;
    logic            ans_ok;
    logic            at_last;
    logic            tmo_hit;
    logic            life_loss;
    logic [ANS_W-1:0] slice;

    // Key slice for the current room, from the captured key only.
    always_comb begin
        slice = '0;
        for (int r = 0; r < NUM_ROOMS; r++) begin
            if (room_q == RW'(r)) begin
                slice = key_q[r*ANS_W +: ANS_W];
            end
        end
    end

    // Event decode shared by next-state and datapath logic.
    always_comb begin
        in_play   = (state_q == S_PLAY);
        start_go  = start && !in_play;
        ans_hit   = in_play && answer_valid;
        ans_ok    = (answer == slice);
        at_last   = (room_q == LAST_ROOM);
        // An answer on the expiry cycle takes precedence over the timer.
        tmo_hit   = TMO_EN && in_play && !answer_valid
                    && (timer_q == TMO_LAST);
        life_loss = (ans_hit && !ans_ok) || tmo_hit;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            room_q      <= '0;
            prev_room_q <= '0;
            lives_q     <= FULL_LIVES;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            timer_q     <= '0;
            key_q       <= '0;
        end else begin
            state_q     <= state_d;
            room_q      <= room_d;
            prev_room_q <= prev_room_d;
            lives_q     <= lives_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
            timer_q     <= timer_d;
            key_q       <= key_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            start_go: begin
                state_d = S_PLAY;
            end
            (ans_hit && ans_ok && at_last): begin
                state_d = S_WIN;
            end
            (life_loss && lives_q == ONE_LIFE): begin
                state_d = S_LOSE;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        room_d      = room_q;
        prev_room_d = prev_room_q;
        lives_d     = lives_q;
        correct_d   = 1'b0;
        wrong_d     = 1'b0;
        timer_d     = timer_q;
        key_d       = key_q;
        if (start_go) begin
            key_d   = key;
            room_d  = '0;
            lives_d = FULL_LIVES;
            timer_d = '0;
        end else if (ans_hit) begin
            prev_room_d = room_q;
            timer_d     = '0;
            if (ans_ok) begin
                correct_d = 1'b1;
                if (!at_last) begin
                    room_d = room_q + RW'(1);
                end
            end else begin
                wrong_d = 1'b1;
                lives_d = lives_q - ONE_LIFE;
            end
        end else if (tmo_hit) begin
            wrong_d = 1'b1;
            lives_d = lives_q - ONE_LIFE;
            timer_d = '0;
        end else if (TMO_EN && in_play) begin
            timer_d = timer_q + TW'(1);
        end
    end

    assign state         = state_q;
    assign room          = room_q;
    assign prev_room     = prev_room_q;
    assign lives         = lives_q;
    assign correct_pulse = correct_q;
    assign wrong_pulse   = wrong_q;

    a_pulse_excl : assert property (
        @(posedge clk) disable iff (reset)
        !(correct_q && wrong_q));

    a_room_range : assert property (
        @(posedge clk) disable iff (reset)
        room_q <= LAST_ROOM);

    a_lives_range : assert property (
        @(posedge clk) disable iff (reset)
        lives_q <= FULL_LIVES);

    a_play_alive : assert property (
        @(posedge clk) disable iff (reset)
        (state_q == S_PLAY) |-> (lives_q != '0));

endmodule

// File: tb/tb_escape_room_fsm.sv
// Bench for escape_room_fsm: untimed and TIMEOUT=10 instances
// driven together, checked against a per-instance game model.
module tb_escape_room_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        answer_valid;
    logic [1:0]  answer;
    logic [11:0] key;

    logic [1:0] st0, st1;
    logic [2:0] rm0, rm1, pv0, pv1;
    logic [1:0] lv0, lv1;
    logic       cp0, cp1, wp0, wp1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    escape_room_fsm #(
        .NUM_ROOMS(6), .ANS_W(2), .MAX_LIVES(3), .TIMEOUT(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .answer_valid(answer_valid), .answer(answer), .key(key),
        .state(st0), .room(rm0), .prev_room(pv0), .lives(lv0),
        .correct_pulse(cp0), .wrong_pulse(wp0)
    );

    escape_room_fsm #(
        .NUM_ROOMS(6), .ANS_W(2), .MAX_LIVES(3), .TIMEOUT(10)
    ) dut_t (
        .clk(clk), .reset(reset), .start(start),
        .answer_valid(answer_valid), .answer(answer), .key(key),
        .state(st1), .room(rm1), .prev_room(pv1), .lives(lv1),
        .correct_pulse(cp1), .wrong_pulse(wp1)
    );

    // Game model: one entry per instance (0 untimed, 1 TIMEOUT=10).
    int m_st[2], m_room[2], m_prev[2], m_lives[2];
    int m_cp[2], m_wp[2], m_tmr[2];
    int m_key[2][6];
    int m_to[2] = '{0, 10};
    bit m_valid = 1'b0;

    task automatic model_step(input int d);
        bit lose;
        if (reset) begin
            m_st[d] = 0; m_room[d] = 0; m_prev[d] = 0;
            m_lives[d] = 3; m_cp[d] = 0; m_wp[d] = 0;
            m_tmr[d] = 0;
            for (int r = 0; r < 6; r++) m_key[d][r] = 0;
            return;
        end
        m_cp[d] = 0;
        m_wp[d] = 0;
        lose = 1'b0;
        if (m_st[d] != 1) begin
            if (start) begin
                m_st[d] = 1; m_room[d] = 0;
                m_lives[d] = 3; m_tmr[d] = 0;
                for (int r = 0; r < 6; r++)
                    m_key[d][r] = (int'(key) >> (2 * r)) & 3;
            end
        end else begin
            if (answer_valid) begin
                m_prev[d] = m_room[d];
                m_tmr[d] = 0;
                if (int'(answer) == m_key[d][m_room[d]]) begin
                    m_cp[d] = 1;
                    if (m_room[d] == 5) m_st[d] = 2;
                    else m_room[d]++;
                end else begin
                    lose = 1'b1;
                end
            end else if (m_to[d] > 0) begin
                if (m_tmr[d] == m_to[d] - 1) begin
                    m_tmr[d] = 0;
                    lose = 1'b1;
                end else begin
                    m_tmr[d]++;
                end
            end
            if (lose) begin
                m_wp[d] = 1;
                m_lives[d]--;
                if (m_lives[d] == 0) m_st[d] = 3;
            end
        end
    endtask

    task automatic chk(input int d, input int st, input int rm,
                       input int pv, input int lv, input int cp,
                       input int wp);
        n_tests++;
        if (st != m_st[d] || rm != m_room[d] || pv != m_prev[d] ||
            lv != m_lives[d] || cp != m_cp[d] || wp != m_wp[d]) begin
            n_fail++;
            $display("FAIL model_cmp dut%0d t=%0t got st=%0d rm=%0d pv=%0d lv=%0d cp=%0d wp=%0d want st=%0d rm=%0d pv=%0d lv=%0d cp=%0d wp=%0d",
                     d, $time, st, rm, pv, lv, cp, wp,
                     m_st[d], m_room[d], m_prev[d], m_lives[d],
                     m_cp[d], m_wp[d]);
        end
    endtask

    // Compare against the model, then advance it with the inputs
    // that the coming posedge will sample.
    always begin
        @(negedge clk);
        if (m_valid) begin
            chk(0, int'(st0), int'(rm0), int'(pv0), int'(lv0),
                int'(cp0), int'(wp0));
            chk(1, int'(st1), int'(rm1), int'(pv1), int'(lv1),
                int'(cp1), int'(wp1));
        end
        model_step(0);
        model_step(1);
        if (reset) m_valid = 1'b1;
    end

    int cp_cnt[2];
    int wp_cnt[2];

    task automatic tick();
        @(posedge clk);
        #1;
        cp_cnt[0] += int'(cp0); cp_cnt[1] += int'(cp1);
        wp_cnt[0] += int'(wp0); wp_cnt[1] += int'(wp1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic lchk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int a);
        answer_valid = 1'b1;
        answer = 2'(a);
        tick();
        answer_valid = 1'b0;
    endtask

    int t1_ans[6] = '{2, 0, 1, 1, 0, 1};
    int snap;

    initial begin
        reset = 1'b1; start = 1'b0; answer_valid = 1'b0;
        answer = '0; key = '0;
        cp_cnt = '{0, 0}; wp_cnt = '{0, 0};
        ticks(2);
        lchk("rst_state", int'(st0), 0);
        lchk("rst_room", int'(rm0), 0);
        lchk("rst_prev", int'(pv0), 0);
        lchk("rst_lives", int'(lv0), 3);
        reset = 1'b0;

        // T1: clean run through all six rooms
        key = 12'h452;
        do_start();
        lchk("t1_play", int'(st0), 1);
        cp_cnt = '{0, 0};
        for (int i = 0; i < 6; i++) send(t1_ans[i]);
        lchk("t1_cp_cnt", cp_cnt[0], 6);
        lchk("t1_win", int'(st0), 2);
        lchk("t1_room", int'(rm0), 5);
        lchk("t1_lives", int'(lv0), 3);
        lchk("t1_prev", int'(pv0), 5);
        send(1);
        lchk("t1_win_nopulse", int'(cp0) + int'(wp0), 0);
        tick();

        // T2: restart from WIN, one wrong answer
        do_start();
        lchk("t2_room0", int'(rm0), 0);
        send(2);
        send(3);
        lchk("t2_wp", int'(wp0), 1);
        lchk("t2_lives", int'(lv0), 2);
        lchk("t2_room", int'(rm0), 1);
        send(0);
        lchk("t2_adv", int'(rm0), 2);

        // T6: key change + start mid-PLAY are ignored
        key = 12'h000;
        do_start();
        lchk("t6_still_play", int'(st0), 1);
        lchk("t6_room", int'(rm0), 2);
        send(1);
        lchk("t6_old_key_cp", int'(cp0), 1);
        lchk("t6_room3", int'(rm0), 3);
        send(0);
        lchk("t6_lives1", int'(lv0), 1);

        // T5: reset mid-game
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lchk("t5_idle", int'(st0), 0);
        lchk("t5_room", int'(rm0), 0);
        lchk("t5_lives", int'(lv0), 3);

        // T3: three wrong answers in room 0
        key = 12'hFFF;
        do_start();
        send(0);
        lchk("t3_l2", int'(lv0), 2);
        send(0);
        lchk("t3_l1", int'(lv0), 1);
        send(0);
        lchk("t3_l0", int'(lv0), 0);
        lchk("t3_lose", int'(st0), 3);
        send(3);
        lchk("t3_nopulse", int'(cp0) + int'(wp0), 0);

        // T4: room timer on the TIMEOUT=10 instance
        do_start();
        wp_cnt = '{0, 0};
        ticks(9);
        lchk("t4_no_tmo_yet", wp_cnt[1], 0);
        tick();
        lchk("t4_tmo1", wp_cnt[1], 1);
        lchk("t4_lives2", int'(lv1), 2);
        ticks(20);
        lchk("t4_tmo3", wp_cnt[1], 3);
        lchk("t4_lose", int'(st1), 3);
        lchk("t4_untimed_ok", int'(lv0), 3);

        // T4: answer on the expiry edge beats the timer
        do_start();
        ticks(9);
        snap = wp_cnt[1];
        send(3);
        lchk("t4_ans_cp", int'(cp1), 1);
        lchk("t4_ans_nowp", wp_cnt[1] - snap, 0);
        lchk("t4_ans_room", int'(rm1), 1);
        lchk("t4_new_key", int'(rm0), 1);
        ticks(9);
        lchk("t4_restart", wp_cnt[1] - snap, 0);
        tick();
        lchk("t4_tmo_after", int'(wp1), 1);
        lchk("t4_tmo_prev", int'(pv1), 0);
        lchk("t4_tmo_lives", int'(lv1), 2);

        ticks(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
